tanh_lut_arbiter: RTL
=====================

TANH_LUT_ARBITER -- requirements
Module: tanh_lut_arbiter

Interface
REQ-001 The block SHALL have one parameter per line as follows:
  N_REQ, 4, number of requesters sharing the tanh LUT (legal 2..8)
  ID_W, 2, requester-id width, equal to clog2(N_REQ)
REQ-002 The block SHALL have one port per line as follows (clock and reset first):
  clk  in  1  single clock, all state on rising edge
  rst  in  1  asynchronous, active-low reset
  req_valid  in  N_REQ  per-requester request valid
  req_ready  out  N_REQ  per-requester accept, one-hot or zero
  req_data  in  8*N_REQ  signed Q4.4 input x per requester, slice i = bits [8i+7:8i]
  rsp_valid  out  1  result valid
  rsp_ready  in  1  downstream accept
  rsp_id  out  ID_W  index of the requester that owns rsp_data
  rsp_data  out  8  signed tanh(x) result, same scale as the LUT entries

Function
REQ-003 The block SHALL contain a 16-entry signed 8-bit tanh table, where entry 0 is 0, entry 1 is 12, entries 2..7 are 15, entries 8..14 are -15 and entry 15 is -12.
REQ-004 For an input x, the address SHALL be x[7:4] and frac SHALL be x[3:0] (unsigned).
REQ-005 The block SHALL set base = lut[addr] and next = lut[0] if addr==15, lut[7] if addr==7, otherwise lut[addr+1].
REQ-006 The result SHALL be y = base + ((next-base)*frac >>> 4), using a 9-bit signed difference, a 13-bit signed product and an arithmetic shift that floors the value, with y truncated to 8 bits (it stays in range by table construction).
REQ-007 The block SHALL be a 3-stage pipeline: S1 registers the grant, x and id; S2 registers base, next, frac and id; S3 registers y and id into rsp_data and rsp_id; each stage has its own valid bit v1, v2 and v3.
REQ-008 The block SHALL compute advance = !v3 | rsp_ready; all stages SHALL shift only when advance is 1, and otherwise all stage registers hold.
REQ-009 rsp_valid SHALL equal v3, and rsp_data and rsp_id SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-010 The arbiter SHALL be round-robin with pointer ptr: the granted requester is the first i with req_valid[i], searching from ptr upward modulo N_REQ.
REQ-011 req_ready[i] SHALL equal advance & grant[i]; req_ready may depend combinationally on req_valid and rsp_ready, and all req_ready bits SHALL be 0 when advance is 0.
REQ-012 On an accepted request from requester i, ptr SHALL become (i+1) mod N_REQ; with no accepted request, ptr SHALL hold.
REQ-013 Accept-to-rsp_valid latency SHALL be 3 cycles with no backpressure, and throughput SHALL be one result per cycle.
REQ-014 A request arriving while rsp_ready=1 and the pipeline is full SHALL be accepted in the same cycle that S3 is consumed, with no bubble.
REQ-015 Results SHALL leave the block in acceptance order, and no request SHALL be dropped or duplicated.

Reset
REQ-016 While rst=0, the block SHALL immediately force v1, v2 and v3 to 0, rsp_valid to 0, rsp_data to 0, rsp_id to 0, ptr to 0 and req_ready to 0.
REQ-017 Reset asserted mid-operation SHALL discard in-flight results, and the first request after reset release SHALL be granted from ptr=0.

Configuration
REQ-018 With macro TANH_LUT_ARBITER_STATS_EN defined, the block SHALL add port acc_cnt (out, 16 bits), a count of accepted requests that saturates at 0xFFFF, and port cnt_clr (in, 1 bit), a synchronous clear where cnt_clr and an accept in the same cycle gives 1.
REQ-019 Without TANH_LUT_ARBITER_STATS_EN, acc_cnt, cnt_clr and the counter logic SHALL be absent, and all other behaviour SHALL be identical.
REQ-020 acc_cnt SHALL reset to 0 on rst=0.

Verification
REQ-021 Single requester, rsp_ready=1, x=0x08 then 0x18 then 0xF8 then 0xE8 -> rsp_data is 6, 13, -6, -14 at accept+3 cycles each.
REQ-022 Boundary inputs x=0x7F, 0x80, 0x00 -> rsp_data is 15, -15, 0 (saturated top entry, no wrap into the negative half).
REQ-023 All four req_valid high continuously from reset release -> grants go 0,1,2,3,0,... with one req_ready per cycle, and rsp_id follows the same order 3 cycles later.
REQ-024 Pipeline full, then rsp_ready=0 for 5 cycles -> rsp_valid stays 1, rsp_data and rsp_id are unchanged, req_ready=0; after rsp_ready returns to 1, the three held results drain in order.
REQ-025 rst pulsed low while v1, v2 and v3 are all 1 -> rsp_valid drops to 0 asynchronously; after release, with requesters 2 and 3 valid, requester 2 is granted first.
REQ-026 With STATS_EN defined, 70000 accepts -> acc_cnt=0xFFFF; cnt_clr with a simultaneous accept -> acc_cnt=1.

Source files
------------

// File: rtl/tanh_lut_arbiter.sv
// Round-robin arbiter that shares one piecewise-linear tanh LUT between N_REQ requesters through a 3-stage pipeline.
// Optional accept counter (acc_cnt/cnt_clr) is built when TANH_LUT_ARBITER_STATS_EN is defined.
module tanh_lut_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic signed [7:0]    rsp_data
`ifdef TANH_LUT_ARBITER_STATS_EN
    ,
    output logic [15:0]          acc_cnt,
    input  logic                 cnt_clr
`endif
);

    function automatic logic signed [7:0] lut_entry(input logic [3:0] a);
        logic signed [7:0] e;
        case (a)
            4'd0:                                  e = 8'sd0;
            4'd1:                                  e = 8'sd12;
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:    e = 8'sd15;
            4'd15:                                 e = -8'sd12;
            default:                               e = -8'sd15;
        endcase
        return e;
    endfunction

    logic [7:0]        req_x [N_REQ];
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   gid;
    logic              found;
    int                idx;
    logic              advance;
    logic              accept;
    logic [ID_W-1:0]   ptr_reg;
    logic [ID_W-1:0]   ptr_next;

    logic              v1_reg, v2_reg, v3_reg;
    logic [7:0]        x1_reg;
    logic [ID_W-1:0]   id1_reg, id2_reg;
    logic signed [7:0] base2_reg, next2_reg;
    logic [3:0]        frac2_reg;

    logic [3:0]        addr1;
    logic [3:0]        addr1_next;
    logic signed [8:0] diff;
    logic signed [12:0] prod;
    logic signed [7:0] frac_term;
    logic signed [7:0] y;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign req_x[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        grant = '0;
        gid   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gid        = ID_W'(idx);
            end
        end
    end

    assign advance   = !v3_reg | rsp_ready;
    assign req_ready = {N_REQ{advance & rst}} & grant;
    assign accept    = |req_ready;
    assign ptr_next  = (gid == ID_W'(N_REQ - 1)) ? '0 : gid + 1'b1;
    assign rsp_valid = v3_reg;

    assign addr1      = x1_reg[7:4];
    assign addr1_next = (addr1 == 4'd15) ? 4'd0 :
                        (addr1 == 4'd7)  ? 4'd7 : addr1 + 4'd1;

    // Slopes are never steep enough for y to leave the 8-bit range.
    assign diff      = {next2_reg[7], next2_reg} - {base2_reg[7], base2_reg};
    assign prod      = $signed({{4{diff[8]}}, diff}) * $signed({9'b0, frac2_reg});
    assign frac_term = 8'(prod >>> 4);
    assign y         = base2_reg + frac_term;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg   <= '0;
            v1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            v3_reg    <= 1'b0;
            x1_reg    <= '0;
            id1_reg   <= '0;
            id2_reg   <= '0;
            base2_reg <= '0;
            next2_reg <= '0;
            frac2_reg <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else if (advance) begin
            v1_reg <= accept;
            if (accept) begin
                x1_reg  <= req_x[gid];
                id1_reg <= gid;
                ptr_reg <= ptr_next;
            end
            v2_reg <= v1_reg;
            if (v1_reg) begin
                base2_reg <= lut_entry(addr1);
                next2_reg <= lut_entry(addr1_next);
                frac2_reg <= x1_reg[3:0];
                id2_reg   <= id1_reg;
            end
            v3_reg <= v2_reg;
            if (v2_reg) begin
                rsp_data <= y;
                rsp_id   <= id2_reg;
            end
        end
    end

`ifdef TANH_LUT_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cnt <= '0;
        end else if (cnt_clr) begin
            acc_cnt <= accept ? 16'd1 : 16'd0;
        end else if (accept && acc_cnt != 16'hFFFF) begin
            acc_cnt <= acc_cnt + 16'd1;
        end
    end
`endif

endmodule
